// File: rtl/ram_responder.sv
// ============================================================================
// Module   : ram_responder
// Brief    : Multi-cycle 32-bit word RAM responder with busy/done handshake.
//            Optional err output enabled by defining RAM_ERR_FLAG_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_responder #(
    parameter int ADDR_W  = 12,
    parameter int DEPTH   = 512,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              read_enable,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       data_in,
    output logic [31:0]       data_out,
    output logic              busy,
`ifdef RAM_ERR_FLAG_EN
    output logic              err,
`endif
    output logic              done
);

    localparam int IDX_W  = ADDR_W - 2;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_idx;
    logic [31:0]        r_wdata;
    logic               r_is_wr;
    logic [31:0]        r_mem [0:DEPTH-1];

    logic               w_accept;
    logic               w_last;
    logic               w_in_range;
    logic [MEM_AW-1:0]  w_midx;

    // DONE accepts a new request exactly like IDLE, giving a one-cycle busy gap
    assign w_accept   = ((r_state == S_IDLE) || (r_state == S_DONE)) &&
                        (write_enable || read_enable);
    assign w_last     = (r_state == S_ACCESS) && (r_cnt == '0);
    assign w_in_range = (32'(r_idx) < 32'(DEPTH));
    assign w_midx     = r_idx[MEM_AW-1:0];

    assign busy = (r_state == S_ACCESS);
    assign done = (r_state == S_DONE);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   w_state_nxt = w_accept ? S_ACCESS : S_IDLE;
            S_ACCESS: w_state_nxt = w_last ? S_DONE : S_ACCESS;
            S_DONE:   w_state_nxt = w_accept ? S_ACCESS : S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_wdata  <= 32'h0;
            r_is_wr  <= 1'b0;
            data_out <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_idx   <= addr[ADDR_W-1:2];
                r_wdata <= data_in;
                r_is_wr <= write_enable;
                r_cnt   <= C_CNT_LOAD;
            end else if ((r_state == S_ACCESS) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_last && !r_is_wr) begin
                data_out <= w_in_range ? r_mem[w_midx] : 32'h0;
            end
        end
    end

    // Storage is not reset; a reset edge suppresses the pending commit
    always_ff @(posedge clk) begin
        if (nRst && w_last && r_is_wr && w_in_range) begin
            r_mem[w_midx] <= r_wdata;
        end
    end

`ifdef RAM_ERR_FLAG_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (!nRst) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= (addr[1:0] != 2'b00) ||
                     (32'(addr[ADDR_W-1:2]) >= 32'(DEPTH));
        end
    end

    assign err = done && r_err;
`else
    logic w_unused_addr_lsb;
    assign w_unused_addr_lsb = ^addr[1:0];
`endif

endmodule

`default_nettype wire

// File: tb/tb_ram_responder.sv
// ============================================================================
// Module   : tb_ram_responder
// Brief    : Scoreboard bench for ram_responder (LATENCY=2, DEPTH=512).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_responder;

    localparam int ADDR_W  = 12;
    localparam int DEPTH   = 512;
    localparam int LATENCY = 2;

    logic              clk = 1'b0;
    logic              nRst = 1'b0;
    logic              read_enable = 1'b0;
    logic              write_enable = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [31:0]       data_in = 32'h0;
    logic [31:0]       data_out;
    logic              busy;
    logic              done;
`ifdef RAM_ERR_FLAG_EN
    logic              err;
`endif

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t q_exp[$];
    int   n_vec = 0;
    int   n_bad = 0;

    ram_responder #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .LATENCY(LATENCY)
    ) u_dut (
        .clk         (clk),
        .nRst        (nRst),
        .read_enable (read_enable),
        .write_enable(write_enable),
        .addr        (addr),
        .data_in     (data_in),
        .data_out    (data_out),
        .busy        (busy),
`ifdef RAM_ERR_FLAG_EN
        .err         (err),
`endif
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse retires one scoreboard entry
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (q_exp.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = q_exp.pop_front();
                check("data_out_at_done", data_out, e.data);
`ifdef RAM_ERR_FLAG_EN
                check("err_at_done", 32'(err), 32'(e.err));
`endif
            end
        end
    end

    task automatic access(input logic we, input logic re, input logic [ADDR_W-1:0] a,
                          input logic [31:0] d, input logic [31:0] exp_d,
                          input logic exp_e, input bit scramble);
        int  n;
        int  nb;
        bit  got;
        exp_t e;
        @(negedge clk);
        write_enable = we;
        read_enable  = re;
        addr         = a;
        data_in      = d;
        e.data = exp_d;
        e.err  = exp_e;
        q_exp.push_back(e);
        n = 0; nb = 0; got = 0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (busy) nb++;
            if (done) got = 1;
            else if (scramble && n == 1) begin
                addr    = a ^ 12'h00c;
                data_in = ~d;
            end
        end
        write_enable = 1'b0;
        read_enable  = 1'b0;
        check("done_seen", 32'(got), 32'd1);
        check("busy_cycles", 32'(nb), 32'(LATENCY));
        check("done_cycle", 32'(n), 32'(LATENCY + 1));
    endtask

    initial begin
        logic [5:0] pat;
        exp_t e;

        // Reset held with a write request pending
        write_enable = 1'b1;
        addr         = 12'h004;
        data_in      = 32'hDEADBEEF;
        repeat (2) begin
            @(negedge clk);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            check("rst_data_out", data_out, 32'h0);
        end
        write_enable = 1'b0;
        @(negedge clk);
        nRst = 1'b1;

        access(1, 0, 12'h004, 32'hDEADBEEF, 32'h0, 0, 0);
        access(1, 0, 12'h000, 32'h0BADF00D, 32'h0, 0, 0);
        access(1, 0, 12'h010, 32'h12345678, 32'h0, 0, 0);
        access(0, 1, 12'h010, 32'h0,        32'h12345678, 0, 1);
        @(negedge clk);
        check("data_out_hold", data_out, 32'h12345678);

        // Back-to-back reads with read_enable held across done
        @(negedge clk);
        read_enable = 1'b1;
        addr        = 12'h000;
        e.data = 32'h0BADF00D; e.err = 0; q_exp.push_back(e);
        e.data = 32'hDEADBEEF; e.err = 0; q_exp.push_back(e);
        pat = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            pat = {pat[4:0], busy};
            if (done && i == 2) addr = 12'h004;
        end
        read_enable = 1'b0;
        check("b2b_busy_pattern", 32'(pat), 32'(6'b110110));

        access(1, 1, 12'h020, 32'hA5A5A5A5, 32'hDEADBEEF, 0, 1);
        access(0, 1, 12'h020, 32'h0,        32'hA5A5A5A5, 0, 0);
        access(1, 0, 12'h800, 32'hFFFFFFFF, 32'hA5A5A5A5, 1, 0);
        access(0, 1, 12'h800, 32'h0,        32'h0,        1, 0);
        access(0, 1, 12'h000, 32'h0,        32'h0BADF00D, 0, 0);
        access(0, 1, 12'h013, 32'h0,        32'h12345678, 1, 0);
        access(1, 0, 12'h030, 32'h30303030, 32'h12345678, 0, 0);

        // Reset during the first busy cycle of a write aborts it
        @(negedge clk);
        write_enable = 1'b1;
        addr         = 12'h030;
        data_in      = 32'h00000055;
        @(negedge clk);
        check("abort_busy_before", 32'(busy), 32'd1);
        nRst         = 1'b0;
        write_enable = 1'b0;
        @(negedge clk);
        check("abort_busy_after", 32'(busy), 32'd0);
        check("abort_done_after", 32'(done), 32'd0);
        check("abort_data_out", data_out, 32'h0);
        nRst = 1'b1;

        access(0, 1, 12'h030, 32'h0, 32'h30303030, 0, 0);
        access(0, 1, 12'h004, 32'h0, 32'hDEADBEEF, 0, 0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(q_exp.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
